// File: rtl/bomberman_input_pkg.sv
// bomberman_input_pkg: key bit layout, per-channel state record and counter sizing shared by the input decoder
package bomberman_input_pkg;
  localparam int KEYS_PER_PLAYER = 5;
  localparam int KEY_UP = 0;
  localparam int KEY_DOWN = 1;
  localparam int KEY_LEFT = 2;
  localparam int KEY_RIGHT = 3;
  localparam int KEY_BOMB = 4;
  // armed direction keys, last-pressed flags (1 = right/down/y-axis) and registered outputs
  typedef struct packed {
    logic [3:0] act;
    logic       lx;
    logic       ly;
    logic       la;
    logic       xdir;
    logic       ydir;
    logic       xmov;
    logic       ymov;
    logic       mp;
    logic       bp;
  } chan_t;
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    m = (m > c) ? m : c;
    return $clog2(m + 1);
  endfunction
endpackage

// File: rtl/player_input_channel.sv
// player_input_channel: one player's axis arbitration, move auto-repeat and bomb cooldown (DIAGONAL_LOCK_EN: single-axis movement)
module player_input_channel
  import bomberman_input_pkg::*;
#(
  parameter int REPEAT_DELAY  = 12,
  parameter int REPEAT_PERIOD = 6,
  parameter int BOMB_COOLDOWN = 25
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       enable,
  input  logic [KEYS_PER_PLAYER-1:0] key_i,
  output logic                       bomb_pulse_o,
  output logic                       xdir_o,
  output logic                       ydir_o,
  output logic                       xmov_o,
  output logic                       ymov_o,
  output logic                       move_pulse_o
);
  localparam int CW = cnt_width(REPEAT_DELAY, REPEAT_PERIOD, BOMB_COOLDOWN);
  typedef logic [CW-1:0] cnt_t;
  logic [KEYS_PER_PLAYER-1:0] prev_q, rise;
  logic [3:0] act;
  logic lx, ly, la, xa, ya, xm, ym, xd, yd, mv, chg, fire, bf;
  chan_t s_q, s_d;
  cnt_t rep_q, rep_d, cd_q, cd_d;
  // a key only steers movement once it has been seen rising while enabled, so keys held across a pause stay inert
  always_comb begin
    rise = key_i & ~prev_q;
    act = (s_q.act | rise[3:0]) & key_i[3:0];
    lx = rise[KEY_RIGHT] ? 1'b1 : rise[KEY_LEFT] ? 1'b0 : s_q.lx;
    ly = rise[KEY_DOWN] ? 1'b1 : rise[KEY_UP] ? 1'b0 : s_q.ly;
    la = (rise[KEY_UP] | rise[KEY_DOWN]) ? 1'b1 : (rise[KEY_LEFT] | rise[KEY_RIGHT]) ? 1'b0 : s_q.la;
    xa = act[KEY_LEFT] | act[KEY_RIGHT];
    ya = act[KEY_UP] | act[KEY_DOWN];
`ifdef DIAGONAL_LOCK_EN
    xm = xa & ~(ya & la);
    ym = ya & ~(xa & ~la);
`else
    xm = xa;
    ym = ya;
`endif
    xd = xm ? ((act[KEY_RIGHT] & act[KEY_LEFT]) ? lx : act[KEY_RIGHT]) : s_q.xdir;
    yd = ym ? ((act[KEY_DOWN] & act[KEY_UP]) ? ly : act[KEY_DOWN]) : s_q.ydir;
    mv = xm | ym;
    chg = mv & ({xm, xd, ym, yd} != {s_q.xmov, s_q.xdir, s_q.ymov, s_q.ydir});
    fire = chg | (mv & (rep_q <= cnt_t'(1)));
    rep_d = chg ? cnt_t'(REPEAT_DELAY) : !mv ? '0 : (rep_q <= cnt_t'(1)) ? cnt_t'(REPEAT_PERIOD) : rep_q - cnt_t'(1);
    bf = rise[KEY_BOMB] & (cd_q == '0);
    cd_d = bf ? cnt_t'(BOMB_COOLDOWN) : (cd_q == '0) ? '0 : cd_q - cnt_t'(1);
    s_d = '{act: act, lx: lx, ly: ly, la: la, xdir: xd, ydir: yd, xmov: xm, ymov: ym, mp: fire, bp: bf};
  end
  // prev_key tracks even while paused; everything else is cleared by pause
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prev_q <= '0;
      s_q <= '0;
      rep_q <= '0;
      cd_q <= '0;
    end else begin
      prev_q <= key_i;
      s_q <= enable ? s_d : '0;
      rep_q <= enable ? rep_d : '0;
      cd_q <= enable ? cd_d : '0;
    end
  end
  assign bomb_pulse_o = s_q.bp;
  assign xdir_o = s_q.xdir;
  assign ydir_o = s_q.ydir;
  assign xmov_o = s_q.xmov;
  assign ymov_o = s_q.ymov;
  assign move_pulse_o = s_q.mp;
endmodule

// File: rtl/move_command_decoder.sv
// move_command_decoder: per-player held-key to move/bomb command decoder (DIAGONAL_LOCK_EN selects single-axis movement)
module move_command_decoder
  import bomberman_input_pkg::*;
#(
  parameter int NUM_PLAYERS   = 2,
  parameter int REPEAT_DELAY  = 12,
  parameter int REPEAT_PERIOD = 6,
  parameter int BOMB_COOLDOWN = 25
) (
  input  logic                                   clock,
  input  logic                                   reset,
  input  logic                                   enable,
  input  logic [KEYS_PER_PLAYER*NUM_PLAYERS-1:0] key_held,
  output logic [NUM_PLAYERS-1:0]                 bomb_pulse,
  output logic [NUM_PLAYERS-1:0]                 xdir,
  output logic [NUM_PLAYERS-1:0]                 ydir,
  output logic [NUM_PLAYERS-1:0]                 xmov,
  output logic [NUM_PLAYERS-1:0]                 ymov,
  output logic [NUM_PLAYERS-1:0]                 move_pulse
);
  for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_ch
    player_input_channel #(
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD),
      .BOMB_COOLDOWN(BOMB_COOLDOWN)
    ) u_ch (
      .clock       (clock),
      .reset       (reset),
      .enable      (enable),
      .key_i       (key_held[KEYS_PER_PLAYER*p +: KEYS_PER_PLAYER]),
      .bomb_pulse_o(bomb_pulse[p]),
      .xdir_o      (xdir[p]),
      .ydir_o      (ydir[p]),
      .xmov_o      (xmov[p]),
      .ymov_o      (ymov[p]),
      .move_pulse_o(move_pulse[p])
    );
  end
endmodule

// File: tb/tb_move_command_decoder.sv
// tb_move_command_decoder: directed plus random stimulus checked against a timestamp-based reference model
module tb_move_command_decoder;
  localparam int NP = 2, D = 4, P = 2, C = 5;
  logic clock = 1'b0, reset, enable;
  logic [5*NP-1:0] key_held;
  logic [NP-1:0] bomb_pulse, xdir, ydir, xmov, ymov, move_pulse;
  move_command_decoder #(
    .NUM_PLAYERS(NP), .REPEAT_DELAY(D), .REPEAT_PERIOD(P), .BOMB_COOLDOWN(C)
  ) dut (
    .clock(clock), .reset(reset), .enable(enable), .key_held(key_held),
    .bomb_pulse(bomb_pulse), .xdir(xdir), .ydir(ydir), .xmov(xmov), .ymov(ymov), .move_pulse(move_pulse)
  );
  always #5 clock = ~clock;
  int n_cmp = 0, n_bad = 0, t = 0;
  logic [5*NP-1:0] mprev;
  int pt[NP][4];
  int axt[NP][2];
  int tchg[NP];
  int lastb[NP];
  logic [NP-1:0] exm, exd, eym, eyd, emp, ebp;
  function void mclear(input int p);
    for (int i = 0; i < 4; i++) pt[p][i] = -1;
    axt[p][0] = -1;
    axt[p][1] = -1;
    tchg[p] = 0;
    lastb[p] = -1000;
    exm[p] = 0; exd[p] = 0; eym[p] = 0; eyd[p] = 0; emp[p] = 0; ebp[p] = 0;
  endfunction
  task automatic chk1(input string tag, input logic [NP-1:0] got, input logic [NP-1:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s t=%0d observed %b expected %b", tag, t, got, exp);
    end
  endtask
  task automatic chk();
    chk1("xmov", xmov, exm);
    chk1("xdir", xdir, exd);
    chk1("ymov", ymov, eym);
    chk1("ydir", ydir, eyd);
    chk1("move_pulse", move_pulse, emp);
    chk1("bomb_pulse", bomb_pulse, ebp);
  endtask
  task automatic cyc();
    logic [4:0] k, r;
    logic xa, ya, xm, ym, xd, yd, chg;
    int dt;
    @(posedge clock);
    #1;
    t++;
    for (int p = 0; p < NP; p++) begin
      k = key_held[5*p +: 5];
      r = k & ~mprev[5*p +: 5];
      if (!enable) mclear(p);
      else begin
        for (int i = 0; i < 4; i++) pt[p][i] = !k[i] ? -1 : r[i] ? t : pt[p][i];
        if (r[0] | r[1]) axt[p][1] = t;
        if (r[2] | r[3]) axt[p][0] = t;
        xa = (pt[p][2] >= 0) || (pt[p][3] >= 0);
        ya = (pt[p][0] >= 0) || (pt[p][1] >= 0);
`ifdef DIAGONAL_LOCK_EN
        xm = xa && !(ya && axt[p][1] >= axt[p][0]);
        ym = ya && !(xa && axt[p][0] > axt[p][1]);
`else
        xm = xa;
        ym = ya;
`endif
        xd = xm ? (pt[p][3] >= pt[p][2]) : exd[p];
        yd = ym ? (pt[p][1] >= pt[p][0]) : eyd[p];
        chg = (xm || ym) && ({xm, xd, ym, yd} != {exm[p], exd[p], eym[p], eyd[p]});
        if (chg) tchg[p] = t;
        dt = t - tchg[p];
        emp[p] = (xm || ym) && (dt == 0 || dt == D || (dt > D && (dt - D) % P == 0));
        exm[p] = xm; exd[p] = xd; eym[p] = ym; eyd[p] = yd;
        ebp[p] = r[4] && (t - lastb[p] > C);
        if (ebp[p]) lastb[p] = t;
      end
    end
    mprev = key_held;
    chk();
  endtask
  task automatic do_reset();
    reset = 1'b1;
    #1;
    for (int p = 0; p < NP; p++) mclear(p);
    mprev = '0;
    chk();
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
  endtask
  task automatic key(input int p, input int i, input logic v);
    key_held[5*p + i] = v;
  endtask
  logic tap[8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  initial begin
    enable = 1'b1;
    key_held = '0;
    do_reset();
    repeat (9) cyc();
    key(0, 3, 1); repeat (10) cyc();
    key(0, 3, 0); key(0, 2, 1); repeat (5) cyc();
    key(0, 3, 1); repeat (10) cyc();
    key(0, 3, 0); repeat (4) cyc();
    key(0, 2, 0); repeat (2) cyc();
    key(1, 0, 1); key(1, 1, 1); repeat (3) cyc();
    key(1, 2, 1); repeat (3) cyc();
    key_held[9:5] = '0; repeat (2) cyc();
    for (int i = 0; i < 8; i++) begin
      key(0, 4, tap[i]);
      cyc();
    end
    key(0, 4, 1); repeat (20) cyc();
    key(0, 4, 0); repeat (2) cyc();
    key(0, 3, 1); repeat (7) cyc();
    do_reset();
    repeat (6) cyc();
    key(1, 1, 1); key(1, 4, 1); repeat (2) cyc();
    enable = 1'b0; repeat (3) cyc();
    enable = 1'b1; repeat (5) cyc();
    key(0, 3, 0); key(1, 4, 0); cyc();
    key(0, 3, 1); key(1, 4, 1); repeat (3) cyc();
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < 5*NP; i++) if ($urandom_range(0, 7) == 0) key_held[i] = ~key_held[i];
      if (enable ? ($urandom_range(0, 99) == 0) : ($urandom_range(0, 3) == 0)) enable = ~enable;
      if ($urandom_range(0, 499) == 0) do_reset();
      cyc();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
